// File: rtl/mem_arb_pkg.sv
// Shared types and default parameters for the unified instruction/data memory arbiter.
package mem_arb_pkg;

    localparam int unsigned DEF_ADDR_W         = 32;
    localparam int unsigned DEF_DATA_W         = 32;
    localparam int unsigned DEF_DATA_BURST_MAX = 4;
    localparam int unsigned DEF_TIMEOUT        = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/mem_arb_select.sv
// Owner selection: data wins unless fetch has waited through DATA_BURST_MAX data grants.
module mem_arb_select
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_BURST_MAX = DEF_DATA_BURST_MAX
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       idle,
    input  logic       if_req,
    input  logic       d_req,
    output arb_owner_t owner_c,
    output logic       grant_valid_c
);

    localparam int unsigned SC_W = $clog2(DATA_BURST_MAX + 1);

    logic [SC_W-1:0] starve_cnt;
    logic            starved;

    always_comb begin
        starved       = if_req && (starve_cnt == SC_W'(DATA_BURST_MAX));
        grant_valid_c = idle && (if_req || d_req);
        owner_c       = (d_req && !starved) ? OWN_DATA : OWN_FETCH;
    end

    // Counts data grants that overtook a waiting fetch; saturates at the burst limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (idle) begin
            if (!if_req || owner_c == OWN_FETCH) begin
                starve_cnt <= '0;
            end else if (d_req && starve_cnt != SC_W'(DATA_BURST_MAX)) begin
                starve_cnt <= starve_cnt + SC_W'(1);
            end
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Serialises fetch and data-stage accesses onto one single-port memory, with a
// response watchdog that turns a hung access into an error response.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W         = DEF_ADDR_W,
    parameter int unsigned DATA_W         = DEF_DATA_W,
    parameter int unsigned DATA_BURST_MAX = DEF_DATA_BURST_MAX,
    parameter int unsigned TIMEOUT        = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned WCNT_W = $clog2(TIMEOUT + 1);

    arb_state_t        state;
    arb_state_t        state_nx;
    arb_owner_t        owner;
    arb_owner_t        sel_owner;
    logic              grant_valid;
    logic              timeout;
    logic              resp_fire;
    logic [WCNT_W-1:0] wait_cnt;

    mem_arb_select #(
        .DATA_BURST_MAX(DATA_BURST_MAX)
    ) u_select (
        .clk          (clk),
        .reset        (reset),
        .idle         (state == IDLE),
        .if_req       (if_req),
        .d_req        (d_req),
        .owner_c      (sel_owner),
        .grant_valid_c(grant_valid)
    );

    // A real response in the timeout cycle still wins over the error.
    always_comb begin
        timeout   = (state == WAIT) && (wait_cnt == WCNT_W'(TIMEOUT));
        resp_fire = (state == WAIT) && (mem_rvalid || timeout);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant_valid) state_nx = ISSUE;
            ISSUE:   if (mem_ready)   state_nx = WAIT;
            WAIT:    if (resp_fire)   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Grants and responses are forced low while reset is asserted.
    always_comb begin
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
        if_err    = 1'b0;
        d_err     = 1'b0;
        if_rdata  = '0;
        d_rdata   = '0;
        if (!reset) begin
            if (grant_valid) begin
                if (sel_owner == OWN_DATA) d_gnt = 1'b1;
                else                       if_gnt = 1'b1;
            end
            if (resp_fire) begin
                if (owner == OWN_DATA) begin
                    d_rvalid = 1'b1;
                    d_err    = !mem_rvalid;
                    d_rdata  = mem_rvalid ? mem_rdata : '0;
                end else begin
                    if_rvalid = 1'b1;
                    if_err    = !mem_rvalid;
                    if_rdata  = mem_rvalid ? mem_rdata : '0;
                end
            end
        end
    end

    // Memory-side request registers; held stable from grant until the next grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner     <= OWN_FETCH;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (grant_valid) begin
            owner   <= sel_owner;
            mem_req <= 1'b1;
            if (sel_owner == OWN_DATA) begin
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
            end else begin
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
            end
        end else if (state == ISSUE && mem_ready) begin
            mem_req <= 1'b0;
        end
    end

    // Watchdog: zero on WAIT entry, counts WAIT cycles up to TIMEOUT.
    always_ff @(posedge clk) begin
        if (reset || state != WAIT) begin
            wait_cnt <= '0;
        end else if (!timeout) begin
            wait_cnt <= wait_cnt + WCNT_W'(1);
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Cycle vectors for directed corner cases, then a scoreboarded starvation run.
module tb_unified_mem_arbiter;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    unified_mem_arbiter #(
        .ADDR_W        (32),
        .DATA_W        (32),
        .DATA_BURST_MAX(4),
        .TIMEOUT       (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .if_err    (if_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic         rst;
        logic         ifr;
        logic [31:0]  ifa;
        logic         dr;
        logic         dwe;
        logic [31:0]  da;
        logic [31:0]  dwd;
        logic         mr;
        logic         mv;
        logic [31:0]  md;
        logic [135:0] exp_out;
    } vec_t;

    typedef struct {
        logic        fetch;
        logic [31:0] data;
    } sb_t;

    vec_t vq[$];
    sb_t  sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    wire [135:0] outv = {if_gnt, if_rvalid, if_err, if_rdata,
                         d_gnt, d_rvalid, d_err, d_rdata,
                         mem_req, mem_we, mem_addr, mem_wdata};

    function automatic logic [135:0] eo(
        input logic ifg, input logic ifv, input logic ife, input logic [31:0] ifd,
        input logic dg, input logic dv, input logic de, input logic [31:0] dd,
        input logic mq, input logic mwe, input logic [31:0] ma, input logic [31:0] mwd);
        return {ifg, ifv, ife, ifd, dg, dv, de, dd, mq, mwe, ma, mwd};
    endfunction

    task automatic add(input string n, input logic rst, input logic ifr, input logic [31:0] ifa,
                       input logic dr, input logic dwe, input logic [31:0] da, input logic [31:0] dwd,
                       input logic mr, input logic mv, input logic [31:0] md, input logic [135:0] e);
        vec_t v;
        v.name = n; v.rst = rst; v.ifr = ifr; v.ifa = ifa; v.dr = dr; v.dwe = dwe;
        v.da = da; v.dwd = dwd; v.mr = mr; v.mv = mv; v.md = md; v.exp_out = e;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic        acc;
        logic [31:0] acc_addr;
        logic [31:0] fa;
        logic [31:0] dadr;
        int          grants;
        int          resps;
        logic        exp_fetch;
        sb_t         e;

        reset = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);

        // reset state and single fetch
        add("rst",     1, 0, 32'h0,   0, 0, 32'h0, 32'h0,  0, 0, 32'h0,        eo(0,0,0,32'h0, 0,0,0,32'h0, 0,0,32'h0,32'h0));
        add("f_gnt",   0, 1, 32'h100, 0, 0, 32'h0, 32'h0,  0, 0, 32'h0,        eo(1,0,0,32'h0, 0,0,0,32'h0, 0,0,32'h0,32'h0));
        add("f_iss",   0, 0, 32'h0,   0, 0, 32'h0, 32'h0,  1, 0, 32'h0,        eo(0,0,0,32'h0, 0,0,0,32'h0, 1,0,32'h100,32'h0));
        add("f_rsp",   0, 0, 32'h0,   0, 0, 32'h0, 32'h0,  0, 1, 32'hDEADBEEF, eo(0,1,0,32'hDEADBEEF, 0,0,0,32'h0, 0,0,32'h100,32'h0));
        add("f_idle",  0, 0, 32'h0,   0, 0, 32'h0, 32'h0,  0, 0, 32'h0,        eo(0,0,0,32'h0, 0,0,0,32'h0, 0,0,32'h100,32'h0));
        // data write collides with fetch
        add("c_dgnt",  0, 1, 32'h104, 1, 1, 32'h200, 32'h55, 0, 0, 32'h0,      eo(0,0,0,32'h0, 1,0,0,32'h0, 0,0,32'h100,32'h0));
        add("c_iss",   0, 1, 32'h104, 0, 0, 32'h0, 32'h0,  1, 0, 32'h0,        eo(0,0,0,32'h0, 0,0,0,32'h0, 1,1,32'h200,32'h55));
        add("c_drsp",  0, 1, 32'h104, 0, 0, 32'h0, 32'h0,  0, 1, 32'h11,       eo(0,0,0,32'h0, 0,1,0,32'h11, 0,1,32'h200,32'h55));
        add("c_fgnt",  0, 1, 32'h104, 0, 0, 32'h0, 32'h0,  0, 0, 32'h0,        eo(1,0,0,32'h0, 0,0,0,32'h0, 0,1,32'h200,32'h55));
        add("c_fiss",  0, 0, 32'h0,   0, 0, 32'h0, 32'h0,  1, 0, 32'h0,        eo(0,0,0,32'h0, 0,0,0,32'h0, 1,0,32'h104,32'h0));
        add("c_frsp",  0, 0, 32'h0,   0, 0, 32'h0, 32'h0,  0, 1, 32'hCAFEF00D, eo(0,1,0,32'hCAFEF00D, 0,0,0,32'h0, 0,0,32'h104,32'h0));
        // backpressure: five ISSUE cycles without mem_ready, one stray rvalid among them
        add("b_dgnt",  0, 0, 32'h0,   1, 0, 32'h300, 32'h0, 0, 0, 32'h0,       eo(0,0,0,32'h0, 1,0,0,32'h0, 0,0,32'h104,32'h0));
        for (int i = 0; i < 5; i++)
            add($sformatf("b_hold%0d", i), 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, (i == 2), 32'h0BAD,
                eo(0,0,0,32'h0, 0,0,0,32'h0, 1,0,32'h300,32'h0));
        add("b_acc",   0, 0, 32'h0,   0, 0, 32'h0, 32'h0,  1, 0, 32'h0,        eo(0,0,0,32'h0, 0,0,0,32'h0, 1,0,32'h300,32'h0));
        add("b_rsp",   0, 0, 32'h0,   0, 0, 32'h0, 32'h0,  0, 1, 32'h12345678, eo(0,0,0,32'h0, 0,1,0,32'h12345678, 0,0,32'h300,32'h0));
        // watchdog: error after eight silent WAIT cycles, later stray rvalid ignored
        add("t_dgnt",  0, 0, 32'h0,   1, 1, 32'h400, 32'hAA, 0, 0, 32'h0,      eo(0,0,0,32'h0, 1,0,0,32'h0, 0,0,32'h300,32'h0));
        add("t_iss",   0, 0, 32'h0,   0, 0, 32'h0, 32'h0,  1, 0, 32'h0,        eo(0,0,0,32'h0, 0,0,0,32'h0, 1,1,32'h400,32'hAA));
        for (int i = 0; i < 8; i++)
            add($sformatf("t_wait%0d", i), 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0,
                eo(0,0,0,32'h0, 0,0,0,32'h0, 0,1,32'h400,32'hAA));
        add("t_err",   0, 0, 32'h0,   0, 0, 32'h0, 32'h0,  0, 0, 32'hFFFFFFFF, eo(0,0,0,32'h0, 0,1,1,32'h0, 0,1,32'h400,32'hAA));
        add("t_stray", 0, 0, 32'h0,   0, 0, 32'h0, 32'h0,  0, 1, 32'h0BAD,     eo(0,0,0,32'h0, 0,0,0,32'h0, 0,1,32'h400,32'hAA));
        // response arriving exactly at the timeout cycle wins
        add("p_fgnt",  0, 1, 32'h500, 0, 0, 32'h0, 32'h0,  0, 0, 32'h0,        eo(1,0,0,32'h0, 0,0,0,32'h0, 0,1,32'h400,32'hAA));
        add("p_iss",   0, 0, 32'h0,   0, 0, 32'h0, 32'h0,  1, 0, 32'h0,        eo(0,0,0,32'h0, 0,0,0,32'h0, 1,0,32'h500,32'h0));
        for (int i = 0; i < 8; i++)
            add($sformatf("p_wait%0d", i), 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0,
                eo(0,0,0,32'h0, 0,0,0,32'h0, 0,0,32'h500,32'h0));
        add("p_rsp",   0, 0, 32'h0,   0, 0, 32'h0, 32'h0,  0, 1, 32'h77,       eo(0,1,0,32'h77, 0,0,0,32'h0, 0,0,32'h500,32'h0));
        // reset while in WAIT
        add("r_dgnt",  0, 0, 32'h0,   1, 0, 32'h600, 32'h0, 0, 0, 32'h0,       eo(0,0,0,32'h0, 1,0,0,32'h0, 0,0,32'h500,32'h0));
        add("r_iss",   0, 0, 32'h0,   0, 0, 32'h0, 32'h0,  1, 0, 32'h0,        eo(0,0,0,32'h0, 0,0,0,32'h0, 1,0,32'h600,32'h0));
        add("r_wait",  0, 0, 32'h0,   0, 0, 32'h0, 32'h0,  0, 0, 32'h0,        eo(0,0,0,32'h0, 0,0,0,32'h0, 0,0,32'h600,32'h0));
        add("r_rst",   1, 0, 32'h0,   0, 0, 32'h0, 32'h0,  0, 1, 32'h99,       eo(0,0,0,32'h0, 0,0,0,32'h0, 0,0,32'h600,32'h0));
        add("r_stray", 0, 0, 32'h0,   0, 0, 32'h0, 32'h0,  0, 1, 32'h99,       eo(0,0,0,32'h0, 0,0,0,32'h0, 0,0,32'h0,32'h0));
        add("r_fgnt",  0, 1, 32'h700, 0, 0, 32'h0, 32'h0,  0, 0, 32'h0,        eo(1,0,0,32'h0, 0,0,0,32'h0, 0,0,32'h0,32'h0));
        add("r_iss",   0, 0, 32'h0,   0, 0, 32'h0, 32'h0,  1, 0, 32'h0,        eo(0,0,0,32'h0, 0,0,0,32'h0, 1,0,32'h700,32'h0));
        add("r_rsp",   0, 0, 32'h0,   0, 0, 32'h0, 32'h0,  0, 1, 32'h1234ABCD, eo(0,1,0,32'h1234ABCD, 0,0,0,32'h0, 0,0,32'h700,32'h0));
        add("r_idle",  0, 0, 32'h0,   0, 0, 32'h0, 32'h0,  0, 0, 32'h0,        eo(0,0,0,32'h0, 0,0,0,32'h0, 0,0,32'h700,32'h0));

        foreach (vq[k]) begin
            @(posedge clk); #1;
            reset = vq[k].rst; if_req = vq[k].ifr; if_addr = vq[k].ifa;
            d_req = vq[k].dr; d_we = vq[k].dwe; d_addr = vq[k].da; d_wdata = vq[k].dwd;
            mem_ready = vq[k].mr; mem_rvalid = vq[k].mv; mem_rdata = vq[k].md;
            @(negedge clk);
            chk(vq[k].name, outv, vq[k].exp_out);
        end

        // Both requests held: four data grants then one fetch, repeating.
        acc = 1'b0; acc_addr = '0; fa = 32'h1000; dadr = 32'h2000; grants = 0; resps = 0;
        for (int cyc = 0; cyc < 300 && resps < 15; cyc++) begin
            @(posedge clk); #1;
            reset = 1'b0; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_wdata = '0;
            mem_ready = 1'b1; if_addr = fa; d_addr = dadr;
            mem_rvalid = acc;
            mem_rdata  = acc ? (acc_addr ^ KEY) : 32'h0;
            @(negedge clk);
            if (if_gnt || d_gnt) begin
                exp_fetch = ((grants % 5) == 4);
                chk($sformatf("starve_pat%0d", grants), 136'({if_gnt, d_gnt}),
                    136'(exp_fetch ? 2'b10 : 2'b01));
                e.fetch = if_gnt;
                e.data  = (if_gnt ? fa : dadr) ^ KEY;
                sbq.push_back(e);
                if (if_gnt) fa = fa + 32'd4;
                else        dadr = dadr + 32'd4;
                grants++;
            end
            if (if_rvalid || d_rvalid) begin
                if (sbq.size() == 0) begin
                    chk("sb_unexpected_rsp", 136'({if_rvalid, d_rvalid}), 136'(0));
                end else begin
                    e = sbq.pop_front();
                    chk($sformatf("sb_rsp%0d", resps),
                        136'({if_rvalid, d_rvalid, if_err, d_err, if_rdata, d_rdata}),
                        136'(e.fetch ? {4'b1000, e.data, 32'h0} : {4'b0100, 32'h0, e.data}));
                end
                resps++;
            end
            acc      = mem_req && mem_ready;
            acc_addr = mem_addr;
        end
        chk("sb_resp_count", 136'(resps), 136'(15));

        @(posedge clk); #1;
        if_req = 1'b0; d_req = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Sequencing controller that shares one single-port instruction/data memory between the pipelined RV32I core's fetch port (PCF/InstrF) and its memory-stage port (ALUResultM/WriteDataM/MemWriteM/ReadDataM). It serialises one transaction at a time with a registered request/grant/response handshake. Data accesses take priority, with a bounded-starvation guarantee for fetch. A watchdog terminates hung accesses. The core's HazardU stalls on the request signals until the matching response returns.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- DATA_BURST_MAX, 4, consecutive data grants allowed while fetch is waiting (≥1)
- TIMEOUT, 255, WAIT-state cycles before forced error response (≥1)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  one-cycle pulse: fetch request captured
- if_rvalid  out  1  one-cycle pulse: fetch response
- if_rdata  out  DATA_W  fetch data, valid with if_rvalid
- if_err  out  1  timeout flag, valid with if_rvalid
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = write
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_gnt / d_rvalid / d_rdata / d_err  out  1/1/DATA_W/1  data-side equivalents
- mem_req  out  1  memory request, registered
- mem_we  out  1  registered write enable
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_ready  in  1  memory accepts mem_req this cycle
- mem_rvalid  in  1  response, one per accepted transaction (reads and writes)
- mem_rdata  in  DATA_W  read data

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - Owner selection when any request is high: DATA if d_req && !(if_req && starve_cnt == DATA_BURST_MAX); otherwise FETCH.
  - Pulse the owner's gnt and latch addr/we/wdata (fetch: we=0, wdata=0) into the mem_* registers; go to ISSUE.
  - No request: stay in IDLE.
- ISSUE: mem_req=1. On mem_ready go to WAIT, otherwise hold with all mem_* stable.
- WAIT:
  - On mem_rvalid: the owner's rvalid=1, rdata=mem_rdata (combinational pass-through), err=0; go to IDLE.
  - If wait_cnt reaches TIMEOUT first: owner's rvalid=1, err=1, rdata=0; go to IDLE.
  - A mem_rvalid arriving in the same cycle as timeout takes precedence (err=0).
- starve_cnt (saturating at DATA_BURST_MAX):
  - +1 on each data grant while if_req=1.
  - Cleared on any fetch grant, or in any IDLE cycle with if_req=0.
- wait_cnt: cleared on entering WAIT, +1 per WAIT cycle.
- mem_rvalid outside WAIT is ignored (stale response after reset or timeout).
- Non-owner rvalid/err/rdata are always 0.
- Reset (any state, including mid-transaction):
  - State returns to IDLE; counters, owner, and all mem_* are cleared to 0.
  - Outstanding requesters get no response and must re-request.

## Timing
- Reset values: all outputs 0.
- Grant: same cycle as the IDLE sample. mem_req rises the next cycle.
- Minimum transaction with mem_ready=1 and mem_rvalid one cycle after acceptance:
  - gnt at T, mem_req at T+1, rvalid at T+2.
  - Next grant possible at T+3.
- Throughput: at most one transaction per 3 cycles.
- Owner rvalid follows mem_rvalid with zero-cycle latency.
- gnt and rvalid never overlap for the same port.
- Only one of if_gnt/d_gnt is high in any cycle.

## Structure
- Package mem_arb_pkg:
  - arb_state_t enum {IDLE, ISSUE, WAIT}
  - arb_owner_t enum {OWN_FETCH, OWN_DATA}
  - default parameter constants
- One sub-module, mem_arb_select: combinational owner selection plus starve_cnt register; outputs the chosen owner and a grant-valid signal.
- Top module holds the FSM, mem_* registers, wait_cnt watchdog and response demux.

## Test plan
- Single fetch: if_req, if_addr=0x100; mem_ready=1; mem_rvalid with 0xDEADBEEF one cycle after accept -> if_gnt at T, mem_req/mem_addr=0x100/mem_we=0 at T+1, if_rvalid/if_rdata=0xDEADBEEF at T+2.
- Data write vs fetch collision: d_req/d_we=1/d_addr=0x200/d_wdata=0x55 and if_req in the same cycle -> d_gnt first, mem_we=1/mem_wdata=0x55; if_gnt at the next IDLE.
- Starvation bound: d_req and if_req held continuously, DATA_BURST_MAX=4 -> exactly 4 d_gnt pulses, then 1 if_gnt, and the pattern repeats.
- Memory backpressure: mem_ready low for 5 cycles in ISSUE -> mem_req/mem_addr stable for all 5 cycles; no rvalid until after acceptance.
- Timeout: TIMEOUT=8, mem_rvalid never asserted -> d_rvalid=1, d_err=1, d_rdata=0 after 8 WAIT cycles; a later stray mem_rvalid produces no output.
- Reset mid-WAIT: assert reset while in WAIT -> next cycle all outputs 0 and state IDLE; a following mem_rvalid is ignored; a new if_req is granted normally.
